// File: rtl/pwm_actuator.sv
// Registered PWM actuator: clamps a signed control word into a duty shadow and
// applies it at period boundaries so the drive never changes duty mid-period.
module pwm_actuator #(
  parameter int PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] u_in,
  input  logic        u_valid,
  input  logic        enable,
  output logic        pwm_out,
  output logic        period_tick,
  output logic [15:0] duty_q,
  output logic        sat_hi,
  output logic        sat_lo
);

  localparam logic [15:0] PER  = 16'(PERIOD);
  localparam logic [15:0] LAST = 16'(PERIOD - 1);

  typedef struct packed {
    logic [15:0] val;
    logic        hi;
    logic        lo;
  } clamp_t;

  clamp_t      clamp;
  logic [15:0] cnt, cnt_n, shadow, shadow_n, duty_n;
  logic        run;

  always_comb begin
    clamp.val = u_in;
    clamp.hi  = 1'b0;
    clamp.lo  = 1'b0;
    if (u_in[15]) begin
      clamp.val = '0;
      clamp.lo  = 1'b1;
    end else if (u_in > PER) begin
      clamp.val = PER;
      clamp.hi  = 1'b1;
    end
  end

  assign period_tick = enable && (cnt == LAST);

  // run is enable delayed one edge: the edge that first samples enable=1
  // starts the period at cnt=0 and loads the duty for it.
  always_comb begin
    shadow_n = u_valid ? clamp.val : shadow;
    cnt_n    = '0;
    if (enable && run && !period_tick) cnt_n = cnt + 16'd1;
    duty_n   = duty_q;
    if (!enable || !run || period_tick) duty_n = shadow_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      run     <= 1'b0;
      shadow  <= '0;
      duty_q  <= '0;
      pwm_out <= 1'b0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      run     <= enable;
      shadow  <= shadow_n;
      duty_q  <= duty_n;
      pwm_out <= enable && (cnt_n < duty_n);
      if (u_valid) begin
        sat_hi <= clamp.hi;
        sat_lo <= clamp.lo;
      end
    end
  end

endmodule

// File: tb/tb_pwm_actuator.sv
// Directed bench for pwm_actuator with PERIOD=10: clamp table plus
// period-level sequences for capture timing, enable and reset corners.
module tb_pwm_actuator;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] u_in;
  logic        u_valid;
  logic        enable;
  logic        pwm_out, period_tick, sat_hi, sat_lo;
  logic [15:0] duty_q;

  int nvec = 0;
  int nerr = 0;

  pwm_actuator #(.PERIOD(10)) dut (
    .clk(clk), .reset(reset), .u_in(u_in), .u_valid(u_valid), .enable(enable),
    .pwm_out(pwm_out), .period_tick(period_tick), .duty_q(duty_q),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] u;
    logic [15:0] duty;
    logic        hi;
    logic        lo;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".pwm"},  32'(pwm_out), 0);
    chk({nm, ".tick"}, 32'(period_tick), 0);
    chk({nm, ".duty"}, 32'(duty_q), 0);
    chk({nm, ".hi"},   32'(sat_hi), 0);
    chk({nm, ".lo"},   32'(sat_lo), 0);
  endtask

  // Observe one full period starting at its cnt=0 cycle; optionally pulse
  // u_valid with cap_val during the cycle at offset cap_at.
  task automatic measure(input string nm, input int hi, input int cap_at,
                         input logic [15:0] cap_val);
    for (int i = 0; i < 10; i++) begin
      chk({nm, ".pwm"},  32'(pwm_out), 32'(i < hi));
      chk({nm, ".tick"}, 32'(period_tick), 32'(i == 9));
      chk({nm, ".duty"}, 32'(duty_q), 32'(hi));
      if (i == cap_at) begin
        u_in    = cap_val;
        u_valid = 1'b1;
      end
      cyc();
      u_valid = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{16'd4,      16'd4,  1'b0, 1'b0};
    tbl[1] = '{16'hFFF6,   16'd0,  1'b0, 1'b1};
    tbl[2] = '{16'd25,     16'd10, 1'b1, 1'b0};
    tbl[3] = '{16'd10,     16'd10, 1'b0, 1'b0};
    tbl[4] = '{16'd11,     16'd10, 1'b1, 1'b0};
    tbl[5] = '{16'd0,      16'd0,  1'b0, 1'b0};
    tbl[6] = '{16'h8000,   16'd0,  1'b0, 1'b1};
    tbl[7] = '{16'h7FFF,   16'd10, 1'b1, 1'b0};
    tbl[8] = '{16'd9,      16'd9,  1'b0, 1'b0};

    reset = 1'b0; enable = 1'b0; u_valid = 1'b0; u_in = '0;
    #12;
    chk_zero("reset0");
    cyc();
    reset = 1'b1;

    // Clamp table while idle: duty tracks shadow, flags hold between captures.
    foreach (tbl[k]) begin
      u_in = tbl[k].u; u_valid = 1'b1;
      cyc();
      u_valid = 1'b0;
      chk("cap.duty", 32'(duty_q), 32'(tbl[k].duty));
      chk("cap.hi",   32'(sat_hi), 32'(tbl[k].hi));
      chk("cap.lo",   32'(sat_lo), 32'(tbl[k].lo));
      chk("cap.pwm",  32'(pwm_out), 0);
      chk("cap.tick", 32'(period_tick), 0);
      u_in = 16'hFFFF;
      cyc();
      chk("hold.duty", 32'(duty_q), 32'(tbl[k].duty));
      chk("hold.hi",   32'(sat_hi), 32'(tbl[k].hi));
      chk("hold.lo",   32'(sat_lo), 32'(tbl[k].lo));
    end

    // Reset clears shadow/duty; release with enable high.
    reset = 1'b0;
    #2;
    chk_zero("reset1");
    cyc();
    reset = 1'b1; enable = 1'b1;
    chk("rel.pwm", 32'(pwm_out), 0);
    cyc();
    measure("p1", 0, 2, 16'd4);
    measure("p2", 4, -1, '0);
    measure("p3", 4, -1, '0);

    // Negative clamp then over-range clamp.
    measure("neg.cap", 4, 3, 16'hFFF6);
    chk("neg.lo", 32'(sat_lo), 1);
    chk("neg.hi", 32'(sat_hi), 0);
    measure("neg.run", 0, 3, 16'd25);
    chk("big.hi", 32'(sat_hi), 1);
    chk("big.lo", 32'(sat_lo), 0);
    measure("full.a", 10, -1, '0);
    measure("full.b", 10, 4, 16'd3);

    // Mid-period capture waits for the wrap.
    measure("mid.cur", 3, 5, 16'd7);
    measure("mid.nxt", 7, 9, 16'd8);
    // Capture on the tick cycle bypasses into the next period.
    measure("byp", 8, 9, 16'd6);

    // Enable drop at cnt=2, raise 5 cycles later.
    cyc(); cyc();
    chk("drop.pwm_pre", 32'(pwm_out), 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle.pwm",  32'(pwm_out), 0);
      chk("idle.tick", 32'(period_tick), 0);
      chk("idle.duty", 32'(duty_q), 6);
    end
    enable = 1'b1;
    chk("rise.gap", 32'(pwm_out), 0);
    cyc();
    measure("rise", 6, -1, '0);

    // Short reset pulse at cnt=3, with u_valid asserted during it.
    cyc(); cyc(); cyc();
    chk("rst.pre", 32'(pwm_out), 1);
    #1;
    reset = 1'b0; u_in = 16'd9; u_valid = 1'b1;
    #1;
    chk_zero("rst.pulse");
    #1;
    reset = 1'b1; u_valid = 1'b0;
    cyc();
    measure("post.rst", 0, 4, 16'd5);
    measure("post.cap", 5, -1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
